// File: rtl/pe_sequencer.sv
// Sequences buffered activation/weight chunks into a PE for one job at a time and captures its result.
// Define PE_SEQ_WATCHDOG_EN to abort a job whose PE result never arrives in DRAIN and raise a sticky err.
module pe_sequencer #(
    parameter int unsigned CELL_BIT   = 8,
    parameter int unsigned N_CELL     = 9,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_step,
    input  logic [2:0]                   cmd_bound,
    input  logic [15:0]                  cmd_bias,
    input  logic                         dat_valid,
    output logic                         dat_ready,
    input  logic [CELL_BIT*N_CELL-1:0]   dat_in,
    input  logic [CELL_BIT*N_CELL-1:0]   dat_wgt,
    output logic                         pe_en,
    output logic [2:0]                   pe_step,
    output logic [2:0]                   pe_bound_level,
    output logic [15:0]                  pe_bias,
    output logic [CELL_BIT*N_CELL-1:0]   pe_in,
    output logic [CELL_BIT*N_CELL-1:0]   pe_weight,
    input  logic [7:0]                   pe_out,
    input  logic                         pe_out_en,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [7:0]                   res_data,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned CHUNK_W = CELL_BIT * N_CELL;
    localparam int unsigned ENT_W   = 2 * CHUNK_W;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FEED,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t               state;
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [2:0]           feed_left;
`ifdef PE_SEQ_WATCHDOG_EN
    logic [2:0]           wd_cnt;
`endif

    logic                 accept_c;
    logic                 push_c;
    logic                 pop_c;
    logic [CNT_W-1:0]     need_cmd_c;
    logic [CNT_W-1:0]     need_job_c;
    logic [CNT_W-1:0]     count_nxt_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop decision: the first chunk leaves on the edge that enters FEED, so pe_en lines up with FEED.
    always_comb begin
        accept_c    = 1'b0;
        push_c      = dat_valid && dat_ready;
        pop_c       = 1'b0;
        need_cmd_c  = CNT_W'(cmd_step) + CNT_W'(1);
        need_job_c  = CNT_W'(pe_step) + CNT_W'(1);
        case (state)
            ST_IDLE: begin
                accept_c = cmd_valid && cmd_ready;
                pop_c    = accept_c && (count >= need_cmd_c);
            end
            ST_FILL: pop_c = (count >= need_job_c);
            ST_FEED: pop_c = (feed_left != 3'd0);
            default: pop_c = 1'b0;
        endcase
        count_nxt_c = count;
        if (push_c && !pop_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    // Chunk FIFO pointers and occupancy; dat_ready tracks not-full in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dat_ready <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_nxt_c;
            dat_ready <= (count_nxt_c != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {dat_in, dat_wgt};
        end
    end

    // Job sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            pe_en          <= 1'b0;
            pe_step        <= 3'd0;
            pe_bound_level <= 3'd0;
            pe_bias        <= 16'd0;
            pe_in          <= '0;
            pe_weight      <= '0;
            feed_left      <= 3'd0;
            res_valid      <= 1'b0;
            res_data       <= 8'd0;
`ifdef PE_SEQ_WATCHDOG_EN
            wd_cnt         <= 3'd0;
            err            <= 1'b0;
`endif
        end else begin
            pe_en <= pop_c;
            if (pop_c) begin
                pe_in     <= mem[rd_ptr][ENT_W-1:CHUNK_W];
                pe_weight <= mem[rd_ptr][CHUNK_W-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        pe_step        <= cmd_step;
                        pe_bound_level <= cmd_bound;
                        pe_bias        <= cmd_bias;
                        feed_left      <= cmd_step;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= pop_c ? ST_FEED : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (pop_c) begin
                        feed_left <= pe_step;
                        state     <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (feed_left == 3'd0) begin
                        state <= ST_DRAIN;
`ifdef PE_SEQ_WATCHDOG_EN
                        wd_cnt <= 3'd0;
`endif
                    end else begin
                        feed_left <= feed_left - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (pe_out_en) begin
                        res_data  <= pe_out;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
`ifdef PE_SEQ_WATCHDOG_EN
                    else if (wd_cnt == 3'd7) begin
                        err       <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 3'd1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef PE_SEQ_WATCHDOG_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: job-level reference model compared every cycle plus directed literal checks.
module tb_pe_sequencer;

    localparam int CW    = 72;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_step = '0;
    logic [2:0]    cmd_bound = '0;
    logic [15:0]   cmd_bias = '0;
    logic          dat_valid = 1'b0;
    logic          dat_ready;
    logic [CW-1:0] dat_in = '0;
    logic [CW-1:0] dat_wgt = '0;
    logic          pe_en;
    logic [2:0]    pe_step;
    logic [2:0]    pe_bound_level;
    logic [15:0]   pe_bias;
    logic [CW-1:0] pe_in;
    logic [CW-1:0] pe_weight;
    logic [7:0]    pe_out = '0;
    logic          pe_out_en;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_data;
    logic          busy;
    logic          err;

    pe_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_step(cmd_step),
        .cmd_bound(cmd_bound), .cmd_bias(cmd_bias),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in), .dat_wgt(dat_wgt),
        .pe_en(pe_en), .pe_step(pe_step), .pe_bound_level(pe_bound_level), .pe_bias(pe_bias),
        .pe_in(pe_in), .pe_weight(pe_weight), .pe_out(pe_out), .pe_out_en(pe_out_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] chunk_in(input int k);
        return CW'(k) * 72'h010203040506070809;
    endfunction

    function automatic logic [CW-1:0] chunk_wgt(input int k);
        return ~chunk_in(k) ^ CW'(k << 4);
    endfunction

    // PE stand-in: strobes a result two cycles after the last pe_en of a burst.
    bit   mock_on = 1'b1;
    bit   spur = 1'b0;
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    bit   mock_q = 1'b0;
    always @(negedge clk) begin
        h2 = h1;
        h1 = h0;
        h0 = pe_en;
        mock_q = mock_on && h2 && !h1 && !h0;
    end
    assign pe_out_en = mock_q | spur;

    int pe_cnt = 0;
    int runs = 0;
    logic pe_prev = 1'b0;
    always @(negedge clk) begin
        if (pe_en === 1'b1) pe_cnt++;
        if (pe_en === 1'b1 && pe_prev !== 1'b1) runs++;
        pe_prev = pe_en;
    end

    // Reference model: a job waits for step+1 buffered chunks, streams them, waits for the PE, then holds the result.
    typedef logic [2*CW-1:0] ent_t;
    ent_t          q[$];
    bit            m_job = 0, m_send = 0, m_wait = 0, m_hold = 0, m_err = 0, m_en = 0;
    int            m_need = 0, m_sent = 0;
    logic [2:0]    m_step = '0, m_bound = '0;
    logic [15:0]   m_bias = '0;
    logic [7:0]    m_res = '0;
    logic [CW-1:0] m_in = '0, m_wgt = '0;
`ifdef PE_SEQ_WATCHDOG_EN
    int            m_wd = 0;
`endif

    always @(posedge clk) begin : model
        int   sz;
        bit   pop;
        bit   psh;
        ent_t e;
        if (!reset) begin
            q.delete();
            m_job = 0; m_send = 0; m_wait = 0; m_hold = 0; m_err = 0; m_en = 0;
            m_need = 0; m_sent = 0; m_step = '0; m_bound = '0; m_bias = '0;
            m_res = '0; m_in = '0; m_wgt = '0;
        end else begin
            sz  = q.size();
            psh = dat_valid && (sz < DEPTH);
            pop = 0;
            if (m_hold) begin
                if (res_ready) begin m_hold = 0; m_job = 0; end
            end else if (m_wait) begin
                if (pe_out_en) begin m_res = pe_out; m_wait = 0; m_hold = 1; end
`ifdef PE_SEQ_WATCHDOG_EN
                else if (m_wd == 7) begin m_err = 1; m_wait = 0; m_job = 0; end
                else m_wd++;
`endif
            end else if (m_send) begin
                if (m_sent == m_need) begin
                    m_send = 0; m_wait = 1;
`ifdef PE_SEQ_WATCHDOG_EN
                    m_wd = 0;
`endif
                end else pop = 1;
            end else begin
                if (!m_job && cmd_valid) begin
                    m_job = 1; m_step = cmd_step; m_bound = cmd_bound; m_bias = cmd_bias;
                    m_need = int'(cmd_step) + 1; m_sent = 0;
                end
                if (m_job && sz >= m_need) begin m_send = 1; pop = 1; end
            end
            m_en = pop;
            if (pop) begin
                e = q.pop_front();
                m_in = e[2*CW-1:CW];
                m_wgt = e[CW-1:0];
                m_sent++;
            end
            if (psh) q.push_back({dat_in, dat_wgt});
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("cmd_ready", CW'(cmd_ready), CW'(!m_job));
            cmp("busy", CW'(busy), CW'(m_job));
            cmp("dat_ready", CW'(dat_ready), CW'(q.size() < DEPTH));
            cmp("pe_en", CW'(pe_en), CW'(m_en));
            cmp("pe_in", pe_in, m_in);
            cmp("pe_weight", pe_weight, m_wgt);
            cmp("pe_step", CW'(pe_step), CW'(m_step));
            cmp("pe_bound_level", CW'(pe_bound_level), CW'(m_bound));
            cmp("pe_bias", CW'(pe_bias), CW'(m_bias));
            cmp("res_valid", CW'(res_valid), CW'(m_hold));
            cmp("res_data", CW'(res_data), CW'(m_res));
            cmp("err", CW'(err), CW'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int k);
        dat_valid = 1'b1;
        dat_in    = chunk_in(k);
        dat_wgt   = chunk_wgt(k);
        tick();
        dat_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] s, input logic [2:0] b, input logic [15:0] bias);
        cmd_valid = 1'b1;
        cmd_step  = s;
        cmd_bound = b;
        cmd_bias  = bias;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        cmp(name, CW'(res_valid), CW'(1));
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        cmp("cmd_ready_after_hs", CW'(cmd_ready), CW'(1));
    endtask

    task automatic clear_cnt();
        pe_cnt = 0;
        runs = 0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        tick();
        chk_on = 1'b1;
        repeat (2) tick();
        cmp("rst_cmd_ready", CW'(cmd_ready), CW'(1));
        cmp("rst_dat_ready", CW'(dat_ready), CW'(1));
        cmp("rst_busy", CW'(busy), CW'(0));
        cmp("rst_res_data", CW'(res_data), CW'(0));
        reset = 1'b1;
        tick();

        // Prefetch then a 3-chunk job
        push(1); push(2); push(3);
        clear_cnt();
        pe_out = 8'hA5;
        send_cmd(3'd2, 3'd3, 16'h0100);
        wait_res("t1_res_timeout");
        cmp("t1_pe_cnt", CW'(pe_cnt), CW'(3));
        cmp("t1_runs", CW'(runs), CW'(1));
        cmp("t1_res_data", CW'(res_data), CW'(8'hA5));
        cmp("t1_pe_bias", CW'(pe_bias), CW'(16'h0100));
        release_res();

        // Trickled chunks: no pe_en until four are buffered
        clear_cnt();
        pe_out = 8'h5A;
        send_cmd(3'd3, 3'd1, 16'hFFFB);
        for (int k = 10; k < 14; k++) begin
            push(k);
            tick();
            if (k == 12) begin
                cmp("t2_no_feed_yet", CW'(pe_cnt), CW'(0));
                cmp("t2_busy", CW'(busy), CW'(1));
            end
        end
        wait_res("t2_res_timeout");
        cmp("t2_pe_cnt", CW'(pe_cnt), CW'(4));
        cmp("t2_runs", CW'(runs), CW'(1));
        cmp("t2_res_data", CW'(res_data), CW'(8'h5A));
        release_res();

        // step=0 with a stalled consumer and a stray strobe during HOLD
        clear_cnt();
        push(20);
        pe_out = 8'h3C;
        send_cmd(3'd0, 3'd5, 16'h7FFF);
        wait_res("t3_res_timeout");
        for (int i = 0; i < 5; i++) begin
            cmp("t3_hold_valid", CW'(res_valid), CW'(1));
            cmp("t3_hold_data", CW'(res_data), CW'(8'h3C));
            cmp("t3_hold_cmd_ready", CW'(cmd_ready), CW'(0));
            spur   = (i == 2);
            pe_out = (i == 2) ? 8'h77 : 8'h3C;
            tick();
        end
        spur = 1'b0;
        cmp("t3_pe_cnt", CW'(pe_cnt), CW'(1));
        release_res();

        // Fill to full, reject an extra push, then drain all 8
        for (int k = 30; k < 38; k++) push(k);
        cmp("t4_full", CW'(dat_ready), CW'(0));
        push(38);
        clear_cnt();
        pe_out = 8'h81;
        send_cmd(3'd7, 3'd7, 16'h8000);
        wait_res("t4_res_timeout");
        cmp("t4_pe_cnt", CW'(pe_cnt), CW'(8));
        cmp("t4_runs", CW'(runs), CW'(1));
        cmp("t4_dat_ready", CW'(dat_ready), CW'(1));
        cmp("t4_last_in", pe_in, chunk_in(37));
        release_res();

        // Reset in the middle of FEED
        clear_cnt();
        for (int k = 40; k < 46; k++) push(k);
        send_cmd(3'd5, 3'd2, 16'h0042);
        n = 0;
        while (pe_cnt < 2 && n < 30) begin
            tick();
            n++;
        end
        cmp("t5_two_pops", CW'(pe_cnt), CW'(2));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cmp("t5_pe_en", CW'(pe_en), CW'(0));
        cmp("t5_busy", CW'(busy), CW'(0));
        cmp("t5_cmd_ready", CW'(cmd_ready), CW'(1));
        cmp("t5_dat_ready", CW'(dat_ready), CW'(1));
        cmp("t5_pe_bias", CW'(pe_bias), CW'(0));
        cmp("t5_pe_in", pe_in, CW'(0));
        cmp("t5_res_valid", CW'(res_valid), CW'(0));
        repeat (4) tick();
        clear_cnt();
        push(50);
        pe_out = 8'h11;
        send_cmd(3'd0, 3'd0, 16'h0001);
        wait_res("t5_res_timeout");
        cmp("t5_fresh_chunk", pe_in, chunk_in(50));
        cmp("t5_pe_cnt", CW'(pe_cnt), CW'(1));
        release_res();

`ifdef PE_SEQ_WATCHDOG_EN
        // PE never answers: watchdog aborts the job
        mock_on = 1'b0;
        push(60);
        send_cmd(3'd0, 3'd4, 16'h0005);
        n = 0;
        while (pe_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (err !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        cmp("t6_wd_latency", CW'(n), CW'(9));
        cmp("t6_err", CW'(err), CW'(1));
        cmp("t6_busy", CW'(busy), CW'(0));
        cmp("t6_res_valid", CW'(res_valid), CW'(0));
        mock_on = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cmp("t6_err_cleared", CW'(err), CW'(0));
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter CELL_BIT, default 8, width of one activation/weight cell.
REQ-002 SHALL have parameter N_CELL, default 9, cells per chunk; CHUNK_W = CELL_BIT*N_CELL.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, chunk buffer depth; must be at least 8.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- cmd_valid  in  1  job descriptor valid
- cmd_ready  out  1  job descriptor accepted
- cmd_step  in  3  chunks per job minus 1
- cmd_bound  in  3  output bound level
- cmd_bias  in  16  signed bias
- dat_valid  in  1  chunk valid
- dat_ready  out  1  chunk accepted
- dat_in  in  CHUNK_W  activations
- dat_wgt  in  CHUNK_W  weights
- pe_en  out  1  PE enable
- pe_step  out  3  PE step
- pe_bound_level  out  3  PE bound
- pe_bias  out  16  PE bias
- pe_in  out  CHUNK_W  PE activations
- pe_weight  out  CHUNK_W  PE weights
- pe_out  in  8  PE signed result
- pe_out_en  in  1  PE result strobe
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  8  captured signed result
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky watchdog error

Function
REQ-005 SHALL implement the FSM states IDLE, FILL, FEED, DRAIN and HOLD.
REQ-006 In IDLE, cmd_ready SHALL be 1; a cmd_valid&cmd_ready handshake latches step, bound and bias and moves the FSM to FILL.
REQ-007 SHALL contain a FIFO_DEPTH-entry chunk FIFO storing {dat_in, dat_wgt}.
REQ-008 dat_ready SHALL equal the FIFO being not full, in every state including IDLE, so chunks may be prefetched.
REQ-009 FILL SHALL move to FEED when FIFO occupancy is at least step+1; this check also applies on the cycle the command is accepted.
REQ-010 FEED SHALL pop one chunk per cycle for exactly step+1 consecutive cycles with pe_en=1 on each of them and no gaps.
- pe_in and pe_weight carry the popped chunk.
- The PE restarts accumulation from bias if pe_en drops mid-job.
REQ-011 pe_step, pe_bound_level and pe_bias SHALL hold the latched values, unchanged, from command acceptance until DRAIN exits.
REQ-012 pe_en SHALL be 0 in every state except FEED.
REQ-013 DRAIN SHALL wait for pe_out_en=1, capture pe_out into res_data on that cycle, and move to HOLD; nominal latency is 2 cycles after the last pe_en.
REQ-014 HOLD SHALL assert res_valid; on res_valid&res_ready the FSM SHALL return to IDLE. res_data SHALL stay stable while res_valid=1.
REQ-015 cmd_ready SHALL be 0 outside IDLE, so only one job is in flight at a time.
REQ-016 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
- A push while full is impossible because dat_ready=0.
- Pointers wrap modulo FIFO_DEPTH.
REQ-017 With cmd_step=0, FEED SHALL last exactly 1 cycle.
REQ-018 A pe_out_en seen outside DRAIN SHALL be ignored.

Reset
REQ-019 When reset=0 at a clk edge, the block SHALL reset as follows:
- FSM to IDLE and FIFO emptied.
- cmd_ready=1 after reset.
- dat_ready=1 after reset.
- pe_en, res_valid, busy and err = 0.
- res_data, pe_step, pe_bound_level and pe_bias = 0.
- pe_in and pe_weight = 0.
REQ-020 Reset asserted mid-job SHALL abandon the job and drop any buffered chunks; no res_valid follows.

Configuration
REQ-021 Macro PE_SEQ_WATCHDOG_EN SHALL select the DRAIN watchdog.
- Defined: if pe_out_en has not arrived 8 cycles after entry to DRAIN, err is set (sticky until reset) and the FSM returns to IDLE without res_valid.
- Undefined: DRAIN waits indefinitely and err is tied to 0.

Verification
REQ-022 Prefetch 3 chunks, then send cmd step=2, bias=0x0100 -> pe_en high for exactly 3 consecutive cycles; res_valid follows with res_data equal to pe_out at pe_out_en.
REQ-023 Send cmd step=3 with chunks trickled one every 2 cycles -> FSM stays in FILL until 4 chunks are buffered, then 4 contiguous pe_en pulses.
REQ-024 Send step=0 with res_ready held 0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0, and 1 cycle after the handshake cmd_ready=1.
REQ-025 Push 8 chunks with no cmd -> dat_ready=0 at full; then cmd step=7 -> 8 pops, FIFO empty, dat_ready=1.
REQ-026 Reset during FEED (step=5, after 2 pops) -> all outputs at reset values and the FIFO empty on the next cycle.
REQ-027 With PE_SEQ_WATCHDOG_EN defined and pe_out_en never asserted -> err=1 and FSM in IDLE 8 cycles after DRAIN entry.
